// File: rtl/inv_key_sched.sv
// AES-128 decryption key source: expands the cipher key to round 10, then streams keys 10..0.
// Optional INV_KEY_LAST_LOAD_EN adds last_key_load so round key 10 can be loaded directly.

module s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the most significant byte of the table.
  assign y = SBOX_TABLE[(11'd255 - {3'd0, a}) * 11'd8 +: 8];

endmodule

module inv_key_sched #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
`ifdef INV_KEY_LAST_LOAD_EN
  input  logic             last_key_load,
`endif
  input  logic [KEY_W-1:0] rx_key,
  input  logic             key_ready,
  output logic             key_valid,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       key_round,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_SERVE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  localparam logic [3:0] LAST_RND  = 4'(NR);

  logic [1:0]       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       rnd_q, rnd_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_in, rot_w, sub_w, t_w;
  logic [3:0]  rc_idx;
  logic [7:0]  rcon;
  logic [KEY_W-1:0] fwd_key, inv_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // One shared SubWord: forward uses w3, inverse needs the recovered w3 (= w3^w2).
  assign sub_in = (state_q == ST_EXPAND) ? w3 : (w3 ^ w2);
  assign rot_w  = {sub_in[23:0], sub_in[31:24]};

  s_box u_sb0 (.a(rot_w[31:24]), .y(sub_w[31:24]));
  s_box u_sb1 (.a(rot_w[23:16]), .y(sub_w[23:16]));
  s_box u_sb2 (.a(rot_w[15:8]),  .y(sub_w[15:8]));
  s_box u_sb3 (.a(rot_w[7:0]),   .y(sub_w[7:0]));

  assign rc_idx = (state_q == ST_EXPAND) ? (rnd_q + 4'd1) : rnd_q;

  always_comb begin
    rcon = 8'h00;
    case (rc_idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_w = sub_w ^ {rcon, 24'h000000};

  always_comb begin
    logic [31:0] f0, f1, f2;
    f0 = w0 ^ t_w;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    fwd_key = {f0, f1, f2, w3 ^ f2};
    inv_key = {w0 ^ t_w, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    if (start) begin
`ifdef INV_KEY_LAST_LOAD_EN
      if (last_key_load) begin
        state_d = ST_SERVE;
        key_d   = rx_key;
        rnd_d   = LAST_RND;
      end else begin
        state_d = ST_EXPAND;
        key_d   = rx_key;
        rnd_d   = '0;
      end
`else
      state_d = ST_EXPAND;
      key_d   = rx_key;
      rnd_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_EXPAND: begin
          key_d = fwd_key;
          rnd_d = rnd_q + 4'd1;
          if (rnd_q + 4'd1 == LAST_RND) state_d = ST_SERVE;
        end
        ST_SERVE: begin
          if (key_ready) begin
            if (rnd_q != 4'd0) begin
              key_d = inv_key;
              rnd_d = rnd_q - 4'd1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign key_valid = (state_q == ST_SERVE);
  assign round_key = key_valid ? key_q : '0;
  assign key_round = key_valid ? rnd_q : '0;
  assign busy      = (state_q == ST_EXPAND) || (state_q == ST_SERVE);
  assign done      = (state_q == ST_DONE);

endmodule
